// File: rtl/lsu_pkg.sv
// Shared encodings and the alignment rule for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return offset != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Big-endian lane logic: load extraction/extension and subword store merge.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_unsigned,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte k sits at bit {~k, 3'b111}; halfword at {~addr[1], 4'b1111}.
  assign w_byte = i_rdata[{~i_offset, 3'b111} -: 8];
  assign w_half = i_rdata[{~i_offset[1], 4'b1111} -: 16];

  always_comb begin
    case (i_size)
      SZ_BYTE: o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_load = i_rdata;
    endcase
  end

  always_comb begin
    // NOTE: default assignment first so partial lane updates cannot infer a latch.
    o_merged = i_old;
    case (i_size)
      SZ_BYTE: o_merged[{~i_offset, 3'b111} -: 8]     = i_wdata[7:0];
      SZ_HALF: o_merged[{~i_offset[1], 4'b1111} -: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: aligned byte/half/word loads and stores, with
// read-modify-write for subword stores and a busy flag to stall the core.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_wr,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [ADDR_WIDTH+1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  output logic                  o_misalign,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_we,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  state_e                r_state;
  logic                  r_wr;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_merge;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_misalign;

  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_merged;

  lsu_byte_lane u_lane (
    .i_rdata    (i_mem_rdata),
    .i_old      (r_merge),
    .i_wdata    (r_wdata),
    .i_size     (r_size),
    .i_offset   (r_addr[1:0]),
    .i_unsigned (r_unsigned),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_wr       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_merge    <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_rvalid   <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req) begin
            if (is_misaligned(i_size, i_addr[1:0])) begin
              r_misalign <= 1'b1;
            end else begin
              r_wr       <= i_wr;
              r_size     <= i_size;
              r_unsigned <= i_unsigned;
              r_addr     <= i_addr;
              r_wdata    <= i_wdata;
              r_state    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!r_wr) begin
            r_rdata  <= w_load;
            r_rvalid <= 1'b1;
            r_state  <= IDLE;
          end else if (r_size == SZ_WORD) begin
            r_state <= IDLE;
          end else begin
            r_merge <= i_mem_rdata;
            r_state <= WRITE;
          end
        end
        WRITE:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Write strobe comes only from registered state, so reset kills it at once.
  assign o_mem_we    = (r_state == WRITE) ||
                       ((r_state == ACCESS) && r_wr && (r_size == SZ_WORD));
  assign o_mem_wdata = (r_state == WRITE) ? w_merged : r_wdata;
  assign o_mem_addr  = r_addr[ADDR_WIDTH+1:2];
  assign o_busy      = (r_state != IDLE);
  assign o_rdata     = r_rdata;
  assign o_rvalid    = r_rvalid;
  assign o_misalign  = r_misalign;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a cycle-scheduled reference model.
module tb_load_store_unit;

  localparam int NCYC = 2048;

  typedef struct packed {
    logic        busy;
    logic        rvalid;
    logic        misalign;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] mwdata;
    logic [31:0] rdata;
  } sched_t;

  logic        clk;
  logic        rst_n;
  logic        init_mem;
  logic        req, wr, uns;
  logic [1:0]  size;
  logic [6:0]  addr;
  logic [31:0] wdata;
  logic        o_busy, o_rvalid, o_misalign, o_mem_we;
  logic [31:0] o_rdata, o_mem_wdata, mem_rdata;
  logic [4:0]  o_mem_addr;

  logic [31:0] mem     [0:31];
  logic [31:0] ref_mem [0:31];
  sched_t      sched   [0:NCYC-1];
  int          cyc;
  logic [31:0] m_rdata;
  int          errors = 0;
  int          checks = 0;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_wr        (wr),
    .i_size      (size),
    .i_unsigned  (uns),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_busy      (o_busy),
    .o_rdata     (o_rdata),
    .o_rvalid    (o_rvalid),
    .o_misalign  (o_misalign),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_we    (o_mem_we),
    .i_mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input int k);
    case (k)
      0:       return 32'h0000_0006;
      1:       return 32'h80FF_1234;
      2:       return 32'h1122_3344;
      default: return 32'h0;
    endcase
  endfunction

  // Data memory: synchronous write, asynchronous read.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 32; k++) mem[k] <= init_word(k);
    end else if (o_mem_we) begin
      mem[o_mem_addr] <= o_mem_wdata;
    end
  end
  assign mem_rdata = mem[o_mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: on an accepting edge, schedule the outputs of the
  // following cycles from plain shift/mask arithmetic on a word array.
  task automatic model_accept();
    logic [1:0]  off;
    logic [4:0]  wa;
    logic [31:0] w, mask, v;
    int          sh;
    off = addr[1:0];
    wa  = addr[6:2];
    w   = ref_mem[wa];
    if (size == 2'b11 || (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00)) begin
      sched[cyc].misalign = 1'b1;
      return;
    end
    case (size)
      2'b00:   begin mask = 32'hFF;   sh = 24 - 8 * int'(off); end
      2'b01:   begin mask = 32'hFFFF; sh = 16 - 8 * int'(off); end
      default: begin mask = '1;       sh = 0;                  end
    endcase
    sched[cyc].busy = 1'b1;
    if (!wr) begin
      v = (w >> sh) & mask;
      if (!uns && size != 2'b10 && ((v & ~(mask >> 1)) != 0)) v = v | ~mask;
      sched[cyc+1].rvalid = 1'b1;
      sched[cyc+1].rdata  = v;
    end else begin
      v = (w & ~(mask << sh)) | ((wdata & mask) << sh);
      if (size == 2'b10) begin
        sched[cyc].we     = 1'b1;
        sched[cyc].waddr  = wa;
        sched[cyc].mwdata = v;
      end else begin
        sched[cyc+1].busy   = 1'b1;
        sched[cyc+1].we     = 1'b1;
        sched[cyc+1].waddr  = wa;
        sched[cyc+1].mwdata = v;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (init_mem) for (int k = 0; k < 32; k++) ref_mem[k] = init_word(k);
      for (int k = cyc; k < NCYC; k++) sched[k] = '0;
      m_rdata = '0;
    end else if (cyc < NCYC - 2) begin
      if (sched[cyc].we) ref_mem[sched[cyc].waddr] = sched[cyc].mwdata;
      cyc++;
      if (sched[cyc].rvalid) m_rdata = sched[cyc].rdata;
      if (req && !sched[cyc-1].busy) model_accept();
    end
  end

  // Compare every cycle out of reset, mid-cycle.
  always @(negedge clk) begin
    if (rst_n && !init_mem) begin
      check("busy", o_busy, sched[cyc].busy);
      check("rvalid", o_rvalid, sched[cyc].rvalid);
      check("misalign", o_misalign, sched[cyc].misalign);
      check("mem_we", o_mem_we, sched[cyc].we);
      check("rdata", o_rdata, m_rdata);
      if (sched[cyc].we) begin
        check("mem_addr", o_mem_addr, sched[cyc].waddr);
        check("mem_wdata", o_mem_wdata, sched[cyc].mwdata);
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic issue(input logic w, input logic [1:0] s, input logic u,
                       input logic [6:0] a, input logic [31:0] d);
    int n = 0;
    req = 1'b1; wr = w; size = s; uns = u; addr = a; wdata = d;
    while (o_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic do_load(input string name, input logic [1:0] s, input logic u,
                         input logic [6:0] a, input logic [31:0] expv);
    int n = 0;
    issue(1'b0, s, u, a, 32'h0);
    while (!o_rvalid && n < 5) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, 32'd1);
    check(name, o_rdata, expv);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, o_busy, 32'd0);
    check({tag, "_rvalid"}, o_rvalid, 32'd0);
    check({tag, "_misalign"}, o_misalign, 32'd0);
    check({tag, "_we"}, o_mem_we, 32'd0);
    check({tag, "_rdata"}, o_rdata, 32'd0);
    check({tag, "_mem_addr"}, o_mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, o_mem_wdata, 32'd0);
  endtask

  initial begin
    cyc = 0;
    init_mem = 1'b1;
    req = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    init_mem = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    // Loads: word and big-endian subword lanes with extension.
    do_load("lw_0",  2'b10, 1'b0, 7'd0, 32'h0000_0006);
    do_load("lb_5",  2'b00, 1'b0, 7'd5, 32'hFFFF_FFFF);
    do_load("lbu_4", 2'b00, 1'b1, 7'd4, 32'h0000_0080);
    do_load("lh_6",  2'b01, 1'b0, 7'd6, 32'h0000_1234);
    do_load("lh_4",  2'b01, 1'b0, 7'd4, 32'hFFFF_80FF);
    do_load("lhu_4", 2'b01, 1'b1, 7'd4, 32'h0000_80FF);
    do_load("lb_7",  2'b00, 1'b0, 7'd7, 32'h0000_0034);

    // Stores: byte and halfword read-modify-write, then a word store.
    issue(1'b1, 2'b00, 1'b0, 7'd9, 32'h0000_00AA);
    repeat (2) @(negedge clk);
    check("sb_9_word2", mem[2], 32'h11AA_3344);
    issue(1'b1, 2'b01, 1'b0, 7'd10, 32'h0000_BEEF);
    repeat (2) @(negedge clk);
    check("sh_10_word2", mem[2], 32'h11AA_BEEF);
    issue(1'b1, 2'b10, 1'b0, 7'd12, 32'hCAFE_F00D);
    repeat (2) @(negedge clk);
    check("sw_12_word3", mem[3], 32'hCAFE_F00D);

    // Misaligned and illegal requests, back to back.
    issue(1'b0, 2'b01, 1'b0, 7'd3, 32'h0);
    check("lh_3_misalign", o_misalign, 32'd1);
    check("lh_3_busy", o_busy, 32'd0);
    issue(1'b0, 2'b11, 1'b0, 7'd8, 32'h0);
    check("size11_misalign", o_misalign, 32'd1);
    issue(1'b1, 2'b10, 1'b0, 7'd2, 32'hDEAD_BEEF);
    check("sw_2_misalign", o_misalign, 32'd1);
    check("sw_2_we", o_mem_we, 32'd0);
    repeat (2) @(negedge clk);
    check("sw_2_word0", mem[0], 32'h0000_0006);

    // Request held while busy: the load waits for the store to finish.
    issue(1'b1, 2'b00, 1'b0, 7'd12, 32'h0000_0055);
    do_load("lw_12_held", 2'b10, 1'b0, 7'd12, 32'h55FE_F00D);
    check("sb_12_word3", mem[3], 32'h55FE_F00D);

    // Reset during WRITE of a byte store.
    issue(1'b1, 2'b00, 1'b0, 7'd1, 32'h0000_0077);
    @(posedge clk);
    #1 check("write_we", o_mem_we, 32'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(posedge clk);
    #1 check("midreset_word0", mem[0], 32'h0000_0006);
    rst_n = 1'b1;
    @(negedge clk);
    do_load("lw_0_after_reset", 2'b10, 1'b0, 7'd0, 32'h0000_0006);

    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) check("mem_final", mem[k], ref_mem[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
